acc_shift_add: RTL and testbench

//   Accumulator register for the shift-and-add multiplier datapath.

---
 rtl/acc_shift_add.sv | 54 +++++
 tb/tb_acc_shift_add.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/acc_shift_add.sv
// acc_shift_add: accumulator register for a shift-and-add multiplier datapath.
// Each rising clock edge performs exactly one operation, chosen by fixed priority:
// parallel load, add of the input word, logical right shift, or hold.
// The output is driven straight from the register, so there is no combinational
// path from any input to the output.
//
// Ports:
//   clk_i       system clock; all state updates on the rising edge
//   rst_ni      asynchronous active-low reset; clears the accumulator
//   load_i      parallel load of entradas_i (highest priority)
//   ad_i        add entradas_i to the accumulator, modulo 2^WIDTH
//   sh_i        logical right shift by one, MSB filled with zero (lowest priority)
//   entradas_i  data operand (load value or addend)
//   saidas_o    accumulator contents (registered)
module acc_shift_add #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             ad_i,
    input  logic             sh_i,
    input  logic [WIDTH-1:0] entradas_i,
    output logic [WIDTH-1:0] saidas_o
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    // Priority mux. entradas_i only reaches acc_d on the load and add paths, so an
    // idle (possibly X) operand cannot disturb a shift or a hold.
    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = entradas_i;
        end else if (ad_i) begin
            // Same-width add: the carry out is discarded, giving wrap-around.
            acc_d = acc_q + entradas_i;
        end else if (sh_i) begin
            acc_d = {1'b0, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign saidas_o = acc_q;

endmodule

// File: tb/tb_acc_shift_add.sv
module tb_acc_shift_add;

    localparam int unsigned WIDTH = 9;

    logic             clk;
    logic             rst_n;
    logic             load;
    logic             ad;
    logic             sh;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;

    int checks = 0;
    int errors = 0;

    acc_shift_add #(
        .WIDTH(WIDTH)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .load_i    (load),
        .ad_i      (ad),
        .sh_i      (sh),
        .entradas_i(din),
        .saidas_o  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             load;
        logic             ad;
        logic             sh;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [WIDTH-1:0] exp);
        checks++;
        if (dout !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, dout, exp);
        end
    endtask

    // Drive controls at the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic l, input logic a, input logic s,
                        input logic [WIDTH-1:0] d);
        @(negedge clk);
        load = l;
        ad   = a;
        sh   = s;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string n, input logic l, input logic a, input logic s,
                           input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] e);
        vec_t v;
        v.name = n;
        v.load = l;
        v.ad   = a;
        v.sh   = s;
        v.din  = d;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    initial begin
        // Multiplier 5 = 4'b0101, applied LSB first; multiplicand 3 pre-shifted by 4.
        logic [3:0]       mult_bits;
        logic [WIDTH-1:0] mul_exp[4];

        add_vec("load7",       1, 0, 0, 9'd7,   9'd7);
        add_vec("shift7",      0, 0, 1, 9'd0,   9'd3);
        add_vec("add200",      0, 1, 0, 9'd200, 9'd203);
        add_vec("load511",     1, 0, 0, 9'd511, 9'd511);
        add_vec("wrap_add",    0, 1, 0, 9'd2,   9'd1);
        add_vec("load256",     1, 0, 0, 9'd256, 9'd256);
        add_vec("shift_fill",  0, 0, 1, 9'd0,   9'd128);
        add_vec("load100a",    1, 0, 0, 9'd100, 9'd100);
        add_vec("prio_all",    1, 1, 1, 9'd5,   9'd5);
        add_vec("load100b",    1, 0, 0, 9'd100, 9'd100);
        add_vec("prio_ad_sh",  0, 1, 1, 9'd10,  9'd110);
        add_vec("hold1",       0, 0, 0, 9'd3,   9'd110);
        add_vec("hold2",       0, 0, 0, 9'd511, 9'd110);
        add_vec("hold3",       0, 0, 0, 9'h155, 9'd110);
        add_vec("load1",       1, 0, 0, 9'd1,   9'd1);
        add_vec("shift_one",   0, 0, 1, 9'd77,  9'd0);
        add_vec("shift_zero",  0, 0, 1, 9'd99,  9'd0);

        load  = 1'b0;
        ad    = 1'b0;
        sh    = 1'b0;
        din   = '0;
        rst_n = 1'b0;
        #12;
        check("reset_init", 9'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].load, vecs[i].ad, vecs[i].sh, vecs[i].din);
            check(vecs[i].name, vecs[i].exp);
        end

        // Asynchronous reset between edges, without a clock edge.
        step(1, 0, 0, 9'd300);
        check("load300", 9'd300);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 9'd0);

        // Controls held active during reset must not change the register.
        load = 1'b1;
        ad   = 1'b1;
        sh   = 1'b1;
        din  = 9'd9;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dominates", 9'd0);

        // First edge after release performs the selected operation.
        @(negedge clk);
        rst_n = 1'b1;
        load  = 1'b1;
        ad    = 1'b0;
        sh    = 1'b0;
        din   = 9'd33;
        @(posedge clk);
        #1;
        check("first_after_reset", 9'd33);

        // Shift-and-add multiply: 3 * 5 = 15.
        mult_bits  = 4'b0101;
        mul_exp[0] = 9'd26;
        mul_exp[1] = 9'd13;
        mul_exp[2] = 9'd30;
        mul_exp[3] = 9'd15;
        step(1, 0, 0, 9'd5);
        check("mul_load", 9'd5);
        for (int k = 0; k < 4; k++) begin
            if (mult_bits[k]) begin
                step(0, 1, 0, 9'd48);
            end
            step(0, 0, 1, 9'd0);
            check($sformatf("mul_step%0d", k), mul_exp[k]);
        end

        @(negedge clk);
        load = 1'b0;
        ad   = 1'b0;
        sh   = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
